// File: rtl/logging_pkg.sv
// Shared definitions for the logging capture block: register window offsets,
// CTRL/STATUS bit positions and writer FSM state encodings.
package logging_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;

  // Register word index, decoded from sbus byte address bits [2:1]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_WPTR   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CIRC   = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STAT_RUNNING    = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_OVERFLOW   = 2;
  localparam int STAT_WRAPPED    = 3;
  localparam int STAT_FIFO_EMPTY = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [DATA_W-1:0] sat_inc16(input logic [DATA_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/logging_fifo.sv
// Small synchronous sample buffer: first-word-fall-through head, full/empty
// flags, synchronous flush. A push on a full FIFO is taken only with a pop.
module logging_fifo #(
  parameter int DEPTH = 4,  // power of two, at least 2
  parameter int WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/logging_capture.sv
// Sample logger: buffers qualified samples and writes them one word per
// Wishbone cycle into a blockram, with a small sbus register window.
module logging_capture
  import logging_pkg::*;
#(
  parameter int DEPTH      = 2048,  // log words in blockram, 2..4096
  parameter int FIFO_DEPTH = 4      // sample buffer entries, power of two
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sbus_wb_cyc_i,
  input  logic              sbus_wb_stb_i,
  input  logic              sbus_wb_we_i,
  input  logic [15:0]       sbus_wb_adr_i,
  input  logic [1:0]        sbus_wb_sel_i,
  input  logic [15:0]       sbus_wb_dat_i,
  output logic [15:0]       sbus_wb_dat_o,
  output logic              sbus_wb_ack_o,
  input  logic [DATA_W-1:0] sample_dat_i,
  input  logic              sample_vld_i,
  output logic              lbram_wb_cyc_o,
  output logic              lbram_wb_stb_o,
  output logic              lbram_wb_we_o,
  output logic [ADDR_W-1:0] lbram_wb_adr_o,
  output logic [DATA_W-1:0] lbram_wb_dat_o,
  input  logic              lbram_wb_ack_i
);

  logic [1:0]        r_state;
  logic              r_enable;
  logic              r_circ;
  logic              r_overflow;
  logic              r_wrapped;
  logic [ADDR_W-1:0] r_wptr;
  logic [15:0]       r_count;

  logic              w_ctrl_wr;
  logic              w_clear;
  logic              w_done;
  logic              w_running;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_flush;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_head;
  logic [15:0]       w_ctrl;
  logic [15:0]       w_status;
  logic              w_unused;

  assign w_unused = ^{sbus_wb_sel_i, sbus_wb_adr_i[15:3], sbus_wb_adr_i[0]};

  assign sbus_wb_ack_o = sbus_wb_cyc_i && sbus_wb_stb_i;
  assign w_ctrl_wr     = sbus_wb_ack_o && sbus_wb_we_i && (sbus_wb_adr_i[2:1] == REG_CTRL);
  assign w_clear       = w_ctrl_wr && sbus_wb_dat_i[CTRL_CLEAR];

  assign w_done    = (r_state == ST_DONE);
  assign w_running = r_enable && !w_done;
  assign w_push    = w_running && sample_vld_i;
  // CLEAR abandons the in-flight cycle, so a coincident ack is not consumed
  assign w_pop     = (r_state == ST_WRITE) && lbram_wb_ack_i && !w_clear;
  assign w_last    = (r_wptr == ADDR_W'(DEPTH - 1));
  assign w_flush   = w_clear || (w_pop && w_last && !r_circ);

  logging_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .i_push   (w_push),
    .i_dat    (sample_dat_i),
    .i_pop    (w_pop),
    .i_flush  (w_flush),
    .o_head   (w_fifo_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty)
  );

  // Head is stable for the whole WRITE state: pops happen only on ack
  assign lbram_wb_cyc_o = (r_state == ST_WRITE);
  assign lbram_wb_stb_o = (r_state == ST_WRITE);
  assign lbram_wb_we_o  = (r_state == ST_WRITE);
  assign lbram_wb_adr_o = r_wptr;
  assign lbram_wb_dat_o = (r_state == ST_WRITE) ? w_fifo_head : '0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_enable   <= 1'b0;
      r_circ     <= 1'b0;
      r_overflow <= 1'b0;
      r_wrapped  <= 1'b0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else if (w_clear) begin
      r_state    <= ST_IDLE;
      r_enable   <= sbus_wb_dat_i[CTRL_ENABLE];
      r_circ     <= sbus_wb_dat_i[CTRL_CIRC];
      r_overflow <= 1'b0;
      r_wrapped  <= 1'b0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= sbus_wb_dat_i[CTRL_ENABLE];
        r_circ   <= sbus_wb_dat_i[CTRL_CIRC];
      end
      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_enable && !w_fifo_empty) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          // Always pass through IDLE so strobes drop for a cycle between writes
          if (w_pop) begin
            r_count <= sat_inc16(r_count);
            if (w_last) begin
              r_wptr <= '0;
              if (r_circ) begin
                r_wrapped <= 1'b1;
                r_state   <= ST_IDLE;
              end else begin
                r_state   <= ST_DONE;
              end
            end else begin
              r_wptr  <= r_wptr + 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_ctrl                  = '0;
    w_ctrl[CTRL_ENABLE]     = r_enable;
    w_ctrl[CTRL_CIRC]       = r_circ;
    w_status                = '0;
    w_status[STAT_RUNNING]  = w_running;
    w_status[STAT_DONE]     = w_done;
    w_status[STAT_OVERFLOW] = r_overflow;
    w_status[STAT_WRAPPED]  = r_wrapped;
    w_status[STAT_FIFO_EMPTY] = w_fifo_empty;
    sbus_wb_dat_o           = '0;
    case (sbus_wb_adr_i[2:1])
      REG_CTRL:   sbus_wb_dat_o = w_ctrl;
      REG_STATUS: sbus_wb_dat_o = w_status;
      REG_WPTR:   sbus_wb_dat_o = {{(16-ADDR_W){1'b0}}, r_wptr};
      REG_COUNT:  sbus_wb_dat_o = r_count;
      default:    sbus_wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_logging_capture.sv
// Self-checking bench for logging_capture: directed scenarios plus random
// traffic, compared against a queue-based model of the logger.
module tb_logging_capture;

  localparam int DEPTH = 8;
  localparam int FD    = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        sbus_wb_cyc_i, sbus_wb_stb_i, sbus_wb_we_i;
  logic [15:0] sbus_wb_adr_i;
  logic [1:0]  sbus_wb_sel_i;
  logic [15:0] sbus_wb_dat_i;
  logic [15:0] sbus_wb_dat_o;
  logic        sbus_wb_ack_o;
  logic [15:0] sample_dat_i;
  logic        sample_vld_i;
  logic        lbram_wb_cyc_o, lbram_wb_stb_o, lbram_wb_we_o;
  logic [11:0] lbram_wb_adr_o;
  logic [15:0] lbram_wb_dat_o;
  logic        lbram_wb_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  logging_capture #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .sbus_wb_cyc_i  (sbus_wb_cyc_i),
    .sbus_wb_stb_i  (sbus_wb_stb_i),
    .sbus_wb_we_i   (sbus_wb_we_i),
    .sbus_wb_adr_i  (sbus_wb_adr_i),
    .sbus_wb_sel_i  (sbus_wb_sel_i),
    .sbus_wb_dat_i  (sbus_wb_dat_i),
    .sbus_wb_dat_o  (sbus_wb_dat_o),
    .sbus_wb_ack_o  (sbus_wb_ack_o),
    .sample_dat_i   (sample_dat_i),
    .sample_vld_i   (sample_vld_i),
    .lbram_wb_cyc_o (lbram_wb_cyc_o),
    .lbram_wb_stb_o (lbram_wb_stb_o),
    .lbram_wb_we_o  (lbram_wb_we_o),
    .lbram_wb_adr_o (lbram_wb_adr_o),
    .lbram_wb_dat_o (lbram_wb_dat_o),
    .lbram_wb_ack_i (lbram_wb_ack_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending samples, write pointer, word count, flags
  logic [15:0] m_q[$];
  bit          m_en, m_circ, m_done, m_ovf, m_wrap;
  int          m_wptr, m_count;
  int          n_wr;
  bit          prev_ack;
  int          ack_pct = 100;

  task automatic model_reset();
    m_q.delete();
    m_en = 0; m_circ = 0; m_done = 0; m_ovf = 0; m_wrap = 0;
    m_wptr = 0; m_count = 0; prev_ack = 0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s = '0;
    s[0] = m_en && !m_done;
    s[1] = m_done;
    s[2] = m_ovf;
    s[3] = m_wrap;
    s[4] = (m_q.size() == 0);
    return s;
  endfunction

  // One clock cycle, entered and left at the falling edge
  task automatic step(input bit vld, input logic [15:0] sd, input bit wr, input logic [15:0] wd);
    bit running, pop, last_oneshot;
    sample_vld_i  = vld;
    sample_dat_i  = sd;
    sbus_wb_cyc_i = wr;
    sbus_wb_stb_i = wr;
    sbus_wb_we_i  = wr;
    sbus_wb_adr_i = 16'h0000;
    sbus_wb_dat_i = wd;
    lbram_wb_ack_i = lbram_wb_cyc_o && ($urandom_range(0, 99) < ack_pct);
    #1;
    if (prev_ack) check("strobe_gap", lbram_wb_cyc_o, 1'b0);
    if (lbram_wb_cyc_o && m_q.size() == 0) check("spurious_cycle", lbram_wb_cyc_o, 1'b0);
    if (lbram_wb_cyc_o && lbram_wb_ack_i && m_q.size() != 0) begin
      check("wr_adr", lbram_wb_adr_o, m_wptr);
      check("wr_dat", lbram_wb_dat_o, m_q[0]);
      check("wr_stb_we", {lbram_wb_stb_o, lbram_wb_we_o}, 2'b11);
      n_wr++;
    end
    prev_ack     = lbram_wb_cyc_o && lbram_wb_ack_i;
    running      = m_en && !m_done;
    pop          = lbram_wb_cyc_o && lbram_wb_ack_i && m_q.size() != 0;
    last_oneshot = 0;
    if (wr && wd[2]) begin
      m_q.delete();
      m_done = 0; m_ovf = 0; m_wrap = 0; m_wptr = 0; m_count = 0;
      m_en = wd[0]; m_circ = wd[1];
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        if (m_count < 65535) m_count++;
        if (m_wptr == DEPTH - 1) begin
          m_wptr = 0;
          if (m_circ) m_wrap = 1;
          else begin m_done = 1; last_oneshot = 1; end
        end else begin
          m_wptr++;
        end
      end
      if (vld && running) begin
        if (m_q.size() < FD) m_q.push_back(sd);
        else m_ovf = 1;
      end
      if (last_oneshot) m_q.delete();
      if (wr) begin m_en = wd[0]; m_circ = wd[1]; end
    end
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic wr_ctrl(input logic [15:0] wd);
    step(1'b0, 16'h0, 1'b1, wd);
  endtask

  task automatic send(input logic [15:0] sd, input int gap);
    step(1'b1, sd, 1'b0, 16'h0);
    idle(gap - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_q.size() != 0 || lbram_wb_cyc_o) && n < 200) begin
      idle(1);
      n++;
    end
    check("drain_in_time", (n < 200), 1'b1);
  endtask

  // Reads all four registers within one cycle, then lets that cycle pass idle
  task automatic check_regs(input string tag);
    logic [15:0] exp_v [4];
    exp_v[0] = {14'b0, m_circ, m_en};
    exp_v[1] = m_status();
    exp_v[2] = 16'(m_wptr);
    exp_v[3] = 16'(m_count);
    sample_vld_i   = 1'b0;
    lbram_wb_ack_i = 1'b0;
    sbus_wb_cyc_i  = 1'b1;
    sbus_wb_stb_i  = 1'b1;
    sbus_wb_we_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sbus_wb_adr_i = 16'(i * 2);
      #1;
      check($sformatf("%s_reg%0d", tag, i), sbus_wb_dat_o, exp_v[i]);
    end
    check({tag, "_ack"}, sbus_wb_ack_o, 1'b1);
    sbus_wb_cyc_i = 1'b0;
    sbus_wb_stb_i = 1'b0;
    prev_ack = 0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rc;
    int         vld_pct;
    int         rv;
    wb_rst_i = 1'b1;
    sbus_wb_cyc_i = 0; sbus_wb_stb_i = 0; sbus_wb_we_i = 0;
    sbus_wb_adr_i = '0; sbus_wb_sel_i = 2'b11; sbus_wb_dat_i = '0;
    sample_dat_i = '0; sample_vld_i = 0; lbram_wb_ack_i = 0;
    model_reset();
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    check("rst_strobes", {lbram_wb_cyc_o, lbram_wb_stb_o, lbram_wb_we_o}, 3'b000);
    check("rst_adr", lbram_wb_adr_o, 12'h000);
    check("rst_dat", lbram_wb_dat_o, 16'h0000);
    @(negedge wb_clk_i);
    check_regs("reset");

    // Three samples into an enabled one-shot log
    ack_pct = 100; n_wr = 0;
    wr_ctrl(16'h0001);
    send(16'hA001, 1); send(16'hA002, 1); send(16'hA003, 1);
    drain();
    check("basic_writes", n_wr, 3);
    check_regs("basic");

    // One-shot fill: the ninth sample must not be logged
    wr_ctrl(16'h0005); n_wr = 0;
    for (int i = 0; i < 9; i++) send(16'hB000 + 16'(i), 4);
    drain();
    check("oneshot_writes", n_wr, 8);
    check_regs("oneshot");

    // Circular: wraps to address 0 and keeps counting
    wr_ctrl(16'h0007); n_wr = 0;
    for (int i = 0; i < 10; i++) send(16'hC000 + 16'(i), 4);
    drain();
    check("circ_writes", n_wr, 10);
    check_regs("circ");

    // Stalled blockram: only FD samples survive
    wr_ctrl(16'h0005); ack_pct = 0; n_wr = 0;
    for (int i = 0; i < 6; i++) send(16'hD000 + 16'(i), 1);
    check_regs("ovf_stalled");
    ack_pct = 100;
    drain();
    check("ovf_writes", n_wr, FD);
    check_regs("ovf_drained");

    // CLEAR during a stalled write abandons the cycle
    ack_pct = 0;
    send(16'hE001, 1);
    idle(3);
    check("stall_cyc", lbram_wb_cyc_o, 1'b1);
    wr_ctrl(16'h0005);
    check("clear_cyc", lbram_wb_cyc_o, 1'b0);
    check_regs("clear");

    // Random traffic with occasional control writes
    for (int r = 0; r < 12; r++) begin
      ack_pct = $urandom_range(10, 100);
      vld_pct = $urandom_range(10, 80);
      rc = 3'($urandom_range(0, 3));
      wr_ctrl({13'b0, 1'b1, rc[1], 1'b1});
      for (int c = 0; c < 150; c++) begin
        rv = $urandom_range(0, 99);
        if (rv < 3) begin
          rc = 3'($urandom_range(0, 7));
          wr_ctrl({13'b0, rc});
        end else begin
          step(($urandom_range(0, 99) < vld_pct), 16'($urandom), 1'b0, 16'h0);
        end
      end
      check_regs($sformatf("rand%0d", r));
    end

    // Reset in the middle of a stalled write
    ack_pct = 0;
    wr_ctrl(16'h0005);
    send(16'hF001, 1);
    idle(2);
    check("pre_rst_cyc", lbram_wb_cyc_o, 1'b1);
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_outs", {lbram_wb_cyc_o, lbram_wb_stb_o, lbram_wb_we_o,
                           lbram_wb_adr_o, lbram_wb_dat_o}, 32'h0);
    model_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_regs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logging_capture.md
LOGGING_CAPTURE -- requirements
Module: logging_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, number of 16-bit log words in blockram; range 2..4096.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sample buffer entries; power of two.
REQ-003 wb_clk_i  in  1  master clock, all logic on rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 sbus_wb_cyc_i, sbus_wb_stb_i, sbus_wb_we_i  in  1 each  sbus slave cycle, strobe, write enable.
REQ-006 sbus_wb_adr_i  in  16  byte address; only bits [2:1] decoded.
REQ-007 sbus_wb_sel_i  in  2  byte selects; ignored, all writes full-word.
REQ-008 sbus_wb_dat_i  in  16; sbus_wb_dat_o  out  16; sbus_wb_ack_o  out  1.
REQ-009 sample_dat_i  in  16  sample word; sample_vld_i  in  1  single-cycle qualifier.
REQ-010 lbram_wb_cyc_o, lbram_wb_stb_o, lbram_wb_we_o  out  1 each  blockram master cycle, strobe, write enable.
REQ-011 lbram_wb_adr_o  out  12  word address; lbram_wb_dat_o  out  16  write data; lbram_wb_ack_i  in  1.

Function
REQ-012 Register map: 0x0 CTRL (RW), 0x2 STATUS (R), 0x4 WPTR (R), 0x6 COUNT (R); writes to 0x2-0x6 ignored.
REQ-013 CTRL: bit0 ENABLE, bit1 CIRC (1 circular, 0 one-shot), bit2 CLEAR (self-clearing, reads 0); bits 15:3 read 0.
REQ-014 STATUS: bit0 RUNNING, bit1 DONE, bit2 OVERFLOW (sticky), bit3 WRAPPED (sticky), bit4 FIFO_EMPTY; others 0.
REQ-015 WPTR = {0, next 12-bit write address}; COUNT = 16-bit words written, saturates at 0xFFFF.
REQ-016 sbus_wb_ack_o SHALL equal sbus_wb_cyc_i && sbus_wb_stb_i combinationally; read data combinational from decoded register.
REQ-017 RUNNING = ENABLE && !DONE.
REQ-018 When RUNNING and sample_vld_i, sample SHALL be pushed into FIFO; when not RUNNING, sample_vld_i ignored.
REQ-019 Push while FIFO full and no pop that cycle: sample dropped, OVERFLOW set; push with simultaneous pop on full FIFO accepted, no overflow.
REQ-020 Writer FSM states IDLE, WRITE, DONE.
REQ-021 IDLE -> WRITE when FIFO non-empty and ENABLE=1 and DONE=0.
REQ-022 WRITE: cyc_o=stb_o=we_o=1, adr_o=WPTR, dat_o=FIFO head, all held stable until ack_i.
REQ-023 On ack_i in WRITE: pop FIFO, COUNT++ (saturating), WPTR advances; strobes deasserted at least one cycle (return to IDLE) before next write.
REQ-024 WPTR = DEPTH-1 at ack, CIRC=1: WPTR -> 0, WRAPPED set.
REQ-025 WPTR = DEPTH-1 at ack, CIRC=0: WPTR -> 0, DONE set, FSM -> DONE; remaining FIFO contents discarded.
REQ-026 DONE exits only on CLEAR or reset, to IDLE.
REQ-027 ENABLE cleared during WRITE: current write completes, then IDLE; FIFO contents retained, drained on re-enable.
REQ-028 CLEAR write: next cycle cyc_o/stb_o low (in-flight cycle abandoned), FIFO flushed, WPTR=0, COUNT=0, DONE/OVERFLOW/WRAPPED=0, FSM IDLE; ENABLE/CIRC take written value.
REQ-029 CLEAR coincident with ack_i: CLEAR wins; no increment.

Reset
REQ-030 On wb_rst_i: CTRL=0, WPTR=0, COUNT=0, status flags 0, FIFO empty, FSM IDLE.
REQ-031 Reset outputs: lbram cyc/stb/we=0, adr_o=0, dat_o=0; sbus_wb_ack_o follows REQ-016.

Structure
REQ-032 Register offsets, CTRL/STATUS bit positions, FSM state encodings SHALL live in shared package logging_pkg, also used by the read window.
REQ-033 Sample buffer SHALL be sub-module logging_fifo (sync FIFO, push/pop/full/empty/flush).

Verification
REQ-034 CTRL=0x0001, 3 samples 0xA001..0xA003 -> bram writes at 0,1,2 with those data; WPTR=3, COUNT=3.
REQ-035 DEPTH=8, CTRL=0x0001, 9 samples spaced 4 cycles -> 8 writes, STATUS DONE=1 RUNNING=0, 9th not written, WPTR=0.
REQ-036 DEPTH=8, CTRL=0x0003, 10 samples -> 9th at addr 0, 10th at addr 1, WRAPPED=1, COUNT=10.
REQ-037 ack_i held low, 6 back-to-back samples -> 4 buffered, OVERFLOW=1, after acks exactly 4 writes in order.
REQ-038 CTRL=0x0005 written during stalled WRITE -> cyc_o low next cycle, WPTR=0, COUNT=0, FIFO_EMPTY=1.
REQ-039 wb_rst_i asserted mid-WRITE -> outputs zero immediately, all registers read 0 after release.
